// File: rtl/controle_exibe_sequencia.sv
// Plays the stored sequence on the LEDs: address 0..limite, each word lit T_ON cycles, then blank T_OFF cycles.
// Optional restart input `repetir` is enabled by defining EXIBE_REPETIR_EN.
module controle_exibe_sequencia #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
`ifdef EXIBE_REPETIR_EN
  input  logic              repetir,
`endif
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    CARREGA = 4'd2,
    ACENDE  = 4'd3,
    APAGA   = 4'd4,
    PROXIMO = 4'd5,
    FIM     = 4'd6
  } estado_t;

  estado_t           state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] limite_q, limite_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic              repetir_w;
  logic              ton_fim, toff_fim, ultimo;

`ifdef EXIBE_REPETIR_EN
  assign repetir_w = repetir;
`else
  assign repetir_w = 1'b0;
`endif

  assign ton_fim  = (timer_q == TW'(T_ON - 1));
  assign toff_fim = (timer_q == TW'(T_OFF - 1));
  assign ultimo   = (endereco_q == limite_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL: if (iniciar) state_d = PREPARA;
      PREPARA: state_d = CARREGA;
      CARREGA: state_d = ACENDE;
      ACENDE:  if (ton_fim) state_d = APAGA;
      APAGA:   if (toff_fim) state_d = ultimo ? FIM : PROXIMO;
      PROXIMO: state_d = CARREGA;
      FIM:     state_d = INICIAL;
      default: state_d = INICIAL;
    endcase
    // restart request overrides any timer expiry in the playback states
    if (repetir_w && (state_q == CARREGA || state_q == ACENDE ||
                      state_q == APAGA   || state_q == PROXIMO))
      state_d = PREPARA;
  end

  always_comb begin
    exibindo  = (state_q == PREPARA) || (state_q == CARREGA) || (state_q == ACENDE) ||
                (state_q == APAGA)   || (state_q == PROXIMO);
    pronto    = (state_q == FIM);
    db_estado = state_q;
  end

  always_comb begin
    endereco_d = endereco_q;
    limite_d   = limite_q;
    timer_d    = '0;
    leds_d     = '0;
    if (state_d == state_q && (state_q == ACENDE || state_q == APAGA))
      timer_d = timer_q + TW'(1);
    if (state_q == PREPARA) begin
      endereco_d = '0;
      limite_d   = limite;
    end
    if (state_q == PROXIMO && state_d == CARREGA)
      endereco_d = endereco_q + ADDR_W'(1);
    // pattern is captured when leaving CARREGA and held only while ACENDE continues
    if (state_q == CARREGA && state_d == ACENDE)
      leds_d = dado_mem;
    else if (state_q == ACENDE && state_d == ACENDE)
      leds_d = leds_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q    <= '0;
      endereco_q <= '0;
      limite_q   <= '0;
      leds_q     <= '0;
    end else begin
      timer_q    <= timer_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      leds_q     <= leds_d;
    end
  end

  assign endereco = endereco_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_controle_exibe_sequencia.sv
// Directed bench for controle_exibe_sequencia with T_ON=3, T_OFF=2 over a 16-word memory.
module tb_controle_exibe_sequencia;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       repetir = 1'b0;
  logic [3:0] limite = '0;
  logic [3:0] dado_mem;
  logic [3:0] endereco, leds, db_estado;
  logic       exibindo, pronto;

  logic [3:0] mem [16];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  controle_exibe_sequencia #(.ADDR_W(4), .DATA_W(4), .T_ON(3), .T_OFF(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
`ifdef EXIBE_REPETIR_EN
    .repetir   (repetir),
`endif
    .limite    (limite),
    .dado_mem  (dado_mem),
    .endereco  (endereco),
    .leds      (leds),
    .exibindo  (exibindo),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;
  assign dado_mem = mem[endereco];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [3:0]  lim;
    int unsigned total;  // edges from iniciar sample to the pronto cycle
    int          chg;    // cycle at which limite is forced to 0 (-1 = never)
    int          ini;    // cycle during which iniciar is pulsed again (-1 = never)
    bit          hold;   // keep iniciar high throughout
  } vec_t;

  // Each item takes 7 cycles: CARREGA, 3x ACENDE, 2x APAGA, PROXIMO/FIM.
  task automatic play(input vec_t v);
    int unsigned i, m;
    bit last;
    logic [3:0] e_db, e_led;
    chk("idle_state", db_estado, 0);
    limite  = v.lim;
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = v.hold;
    chk("prepara", db_estado, 1);
    for (int unsigned n = 1; n <= v.total; n++) begin
      @(posedge clock); #1;
      i    = (n - 1) / 7;
      m    = (n - 1) % 7;
      last = (n == v.total);
      if (m == 0)      e_db = 4'd2;
      else if (m <= 3) e_db = 4'd3;
      else if (m <= 5) e_db = 4'd4;
      else             e_db = last ? 4'd6 : 4'd5;
      e_led = (m >= 1 && m <= 3) ? mem[i] : 4'h0;
      chk("db_estado", db_estado, e_db);
      chk("leds", leds, e_led);
      chk("endereco", endereco, i);
      chk("exibindo", exibindo, !last);
      chk("pronto", pronto, last);
      if (int'(n) == v.chg) limite = 4'h0;
      iniciar = v.hold || (int'(n) == v.ini);
    end
    @(posedge clock); #1;
    chk("back_inicial", db_estado, 0);
    chk("pronto_1cyc", pronto, 0);
    if (v.hold) begin
      @(posedge clock); #1;
      chk("retrigger", db_estado, 1);
      iniciar = 1'b0;
      begin : drain
        for (int k = 0; k < 100; k++) begin
          @(posedge clock); #1;
          if (db_estado == 4'd0) disable drain;
        end
      end
      chk("drain_timeout", db_estado, 0);
    end
  endtask

  vec_t tbl [6];
  bit   seen_pronto;

  initial begin
    mem[0] = 4'h1; mem[1] = 4'h8; mem[2] = 4'h2; mem[3] = 4'h0;
    for (int unsigned k = 4; k < 16; k++) mem[k] = 4'(k) ^ 4'h9;

    tbl[0] = '{lim: 4'd0,  total: 7,   chg: -1, ini: -1, hold: 1'b0};
    tbl[1] = '{lim: 4'd2,  total: 21,  chg: -1, ini: -1, hold: 1'b0};
    tbl[2] = '{lim: 4'd1,  total: 14,  chg: -1, ini: -1, hold: 1'b0};
    tbl[3] = '{lim: 4'd2,  total: 21,  chg: 1,  ini: 3,  hold: 1'b0};
    tbl[4] = '{lim: 4'hF,  total: 112, chg: -1, ini: -1, hold: 1'b0};
    tbl[5] = '{lim: 4'd0,  total: 7,   chg: -1, ini: -1, hold: 1'b1};

    #12;
    chk("rst_leds", leds, 0);
    chk("rst_end", endereco, 0);
    chk("rst_db", db_estado, 0);
    chk("rst_exib", exibindo, 0);
    chk("rst_pronto", pronto, 0);
    iniciar = 1'b1;
    @(posedge clock); #1;
    chk("rst_ignores_iniciar", db_estado, 0);
    iniciar = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    for (int unsigned t = 0; t < 6; t++) play(tbl[t]);

    // Reset asserted mid-ACENDE aborts playback without pronto.
    limite = 4'd2; iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("abort_pre_db", db_estado, 3);
    chk("abort_pre_leds", leds, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_leds", leds, 0);
    chk("abort_end", endereco, 0);
    chk("abort_db", db_estado, 0);
    @(posedge clock); #1;
    chk("abort_db_edge", db_estado, 0);
    @(negedge clock); reset = 1'b1;
    seen_pronto = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      seen_pronto |= pronto;
    end
    chk("abort_no_pronto", seen_pronto, 0);
    chk("abort_idle", db_estado, 0);

`ifdef EXIBE_REPETIR_EN
    // repetir during APAGA of item 1 restarts from address 0.
    limite = 4'd2; iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    chk("rep_pre_db", db_estado, 4);
    chk("rep_pre_end", endereco, 1);
    repetir = 1'b1;
    @(posedge clock); #1;
    repetir = 1'b0;
    chk("rep_prepara", db_estado, 1);
    chk("rep_leds", leds, 0);
    @(posedge clock); #1;
    chk("rep_carrega", db_estado, 2);
    chk("rep_end0", endereco, 0);
    @(posedge clock); #1;
    chk("rep_led0", leds, 1);
    begin : rep_drain
      for (int k = 0; k < 100; k++) begin
        @(posedge clock); #1;
        if (db_estado == 4'd0) disable rep_drain;
      end
    end
    chk("rep_drain", db_estado, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
